program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Parametrised next-generation program counter with a hardware call/return stack and PC-relative branching.
//  Drives the instruction-memory address bus.
//  Sits between the control unit (decoded control strobes) and the instruction memory.
//  All updates are single-cycle and registered.
// PARAMETERS
//  ADDR_W        16   address width in bits
//  STACK_DEPTH   8    return-stack entries (>=2)
//  OFFSET_W      8    width of signed relative-branch offset (<=ADDR_W)
//  RESET_VECTOR  0    address loaded on reset
//  IRQ_VECTOR    16'h0010   interrupt entry address (PC_IRQ_EN only)
// PORTS
//  clk            in   1                     rising-edge clock
//  reset          in   1                     asynchronous, active-high reset
//  count_enable   in   1                     increment address
//  jump_enable    in   1                     absolute jump to jump_address
//  jump_address   in   ADDR_W                absolute target (jump and call)
//  branch_enable  in   1                     relative branch
//  branch_offset  in   OFFSET_W              signed two's-complement offset
//  call_enable    in   1                     push address+1, go to jump_address
//  ret_enable     in   1                     pop top of stack into address
//  address        out  ADDR_W                current program address (registered)
//  stack_depth    out  $clog2(STACK_DEPTH+1) number of valid stack entries
//  stack_full     out  1                     stack_depth==STACK_DEPTH
//  stack_empty    out  1                     stack_depth==0
//  stack_error    out  1                     sticky overflow/underflow flag
// BEHAVIOUR
//  Reset (async assert): address=RESET_VECTOR, stack_depth=0, stack_error=0.
//    stack_empty=1, stack_full=0.
//    Stack contents are don't-care.
//    Reset mid-operation discards all pending stack state.
//  One operation per cycle, chosen by fixed priority:
//    (irq) > jump > call > ret > branch > count > hold.
//    The result appears on address after the sampling edge (1-cycle latency).
//  jump:   address <= jump_address.
//  call:   when not full, push address+1 (mod 2^ADDR_W), address <= jump_address.
//          When full, nothing is pushed, address holds, stack_error <= 1.
//  ret:    when not empty, address <= top, pop.
//          When empty, address holds, stack_error <= 1.
//  branch: address <= address + sign_extend(branch_offset), modulo 2^ADDR_W.
//          Offset 0 holds the address.
//  count:  address <= address+1; 2^ADDR_W-1 wraps to 0.
//  None asserted: hold.
//  Simultaneous strobes: lower-priority strobes are ignored entirely.
//    Example: call+ret performs only the call; depth +1.
//  stack_error clears only on reset.
//  stack_full, stack_empty and stack_depth are combinational from the stack pointer.
// CONFIGURATION
//  PC_IRQ_EN defined:
//    Adds ports irq (in,1) and irq_ack (out,1).
//    irq has the highest priority: push address (the current, un-executed address) and set address <= IRQ_VECTOR.
//    irq_ack pulses for 1 cycle on the same edge.
//    While irq_in_service=1, further irq is masked; the next successful ret clears irq_in_service.
//    irq while the stack is full: not taken, stack_error <= 1, irq_ack stays 0.
//  PC_IRQ_EN undefined: no irq/irq_ack ports and no in-service state.
// STRUCTURE
//  Package pc_pkg:
//    op-select enum PC_OP_{HOLD,COUNT,BRANCH,RET,CALL,JUMP,IRQ}
//    priority-encode function
//  Sub-module pc_return_stack (LIFO):
//    Parameters: DEPTH, WIDTH.
//    Ports: push, pop, din, dout(top), depth, full, empty.
//    Register array plus pointer; push/pop gated by full/empty inside.
//  Top level: priority encoder, address register, error flag.
// TESTING
//  1. Reset, count_enable=1 for 3 cycles -> address 0,1,2,3; hold when count_enable=0.
//  2. address=16'h0005, call_enable, jump_address=16'haa98
//       -> address=aa98, stack_depth=1.
//     Then ret_enable -> address=0006, stack_depth=0, stack_empty=1.
//  3. Nine calls with STACK_DEPTH=8
//       -> stack_full after 8th; 9th: address holds, stack_error=1.
//     Reset -> stack_error=0, address=0.
//  4. ret_enable with empty stack -> address holds, stack_error=1.
//  5. address=16'h0010, branch_offset=8'hFC -> 000C.
//     address=FFFE, branch_offset=8'h03 -> 0001 (wrap).
//     count from FFFF -> 0000.
//  6. jump+call+count same cycle -> jump only, depth unchanged.
//     Assert reset mid-call sequence (depth=3) -> depth=0 asynchronously.
//     PC_IRQ_EN build: irq at 0x0042 -> address=0x0010, irq_ack pulse; ret -> 0x0042.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program sequencer: operation-select encoding
// and the fixed-priority strobe encoder.
package pc_pkg;

  // One operation is executed per cycle; the encoding lists them lowest to highest priority.
  typedef enum logic [2:0] {
    PC_OP_HOLD   = 3'd0,
    PC_OP_COUNT  = 3'd1,
    PC_OP_BRANCH = 3'd2,
    PC_OP_RET    = 3'd3,
    PC_OP_CALL   = 3'd4,
    PC_OP_JUMP   = 3'd5,
    PC_OP_IRQ    = 3'd6
  } pc_op_e;

  // Pick the single highest-priority strobe; lower strobes are ignored entirely.
  function automatic pc_op_e pc_op_select(
    input logic irq,
    input logic jump,
    input logic call,
    input logic ret,
    input logic branch,
    input logic count
  );
    if (irq)         return PC_OP_IRQ;
    else if (jump)   return PC_OP_JUMP;
    else if (call)   return PC_OP_CALL;
    else if (ret)    return PC_OP_RET;
    else if (branch) return PC_OP_BRANCH;
    else if (count)  return PC_OP_COUNT;
    else             return PC_OP_HOLD;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address stack: register array plus a depth pointer.
// Push and pop are ignored when full / empty respectively; the caller
// decides what an illegal request means. dout always shows the top entry.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [WIDTH-1:0]                 din,
  output logic [WIDTH-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]       depth,
  output logic                             full,
  output logic                             empty
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] depth_reg;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (depth_reg == PTR_W'(DEPTH));
  assign empty   = (depth_reg == '0);
  assign depth   = depth_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty && !push;
  assign wr_idx  = IDX_W'(depth_reg);
  assign top_idx = IDX_W'(depth_reg - PTR_W'(1));
  assign dout    = mem[top_idx];

  // Depth pointer: reset clears all pending entries; push wins over a simultaneous pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_reg <= '0;
    end else if (push_ok) begin
      depth_reg <= depth_reg + PTR_W'(1);
    end else if (pop_ok) begin
      depth_reg <= depth_reg - PTR_W'(1);
    end
  end

  // Entry storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with hardware call/return stack and PC-relative branching.
// Optional feature macro: PC_IRQ_EN adds irq/irq_ack and an in-service mask.
module program_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                STACK_DEPTH  = 8,
  parameter int                OFFSET_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
`ifdef PC_IRQ_EN
  ,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(16'h0010)
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               count_enable,
  input  logic                               jump_enable,
  input  logic [ADDR_W-1:0]                  jump_address,
  input  logic                               branch_enable,
  input  logic [OFFSET_W-1:0]                branch_offset,
  input  logic                               call_enable,
  input  logic                               ret_enable,
  output logic [ADDR_W-1:0]                  address,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_error
`ifdef PC_IRQ_EN
  ,
  input  logic                               irq,
  output logic                               irq_ack
`endif
);

  logic [ADDR_W-1:0] address_reg;
  logic [ADDR_W-1:0] address_next;
  logic              error_reg;
  logic              error_next;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] top_data;
  logic [ADDR_W-1:0] offset_ext;
  logic              irq_req;
  pc_op_e            op;

`ifdef PC_IRQ_EN
  logic in_service_reg;
  logic in_service_next;
  logic irq_ack_reg;
  logic irq_ack_next;

  // A second interrupt is masked until the handler returns.
  assign irq_req = irq && !in_service_reg;
  assign irq_ack = irq_ack_reg;
`else
  assign irq_req = 1'b0;
`endif

  assign offset_ext  = ADDR_W'(signed'(branch_offset));
  assign address     = address_reg;
  assign stack_error = error_reg;

  pc_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (top_data),
    .depth (stack_depth),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Next-address selection from the highest-priority strobe, with stack requests and error detection.
  always_comb begin
    op           = pc_op_select(irq_req, jump_enable, call_enable,
                                ret_enable, branch_enable, count_enable);
    address_next = address_reg;
    error_next   = error_reg;
    push         = 1'b0;
    pop          = 1'b0;
    push_data    = address_reg + ADDR_W'(1);
`ifdef PC_IRQ_EN
    in_service_next = in_service_reg;
    irq_ack_next    = 1'b0;
`endif
    case (op)
`ifdef PC_IRQ_EN
      PC_OP_IRQ: begin
        // The interrupted instruction has not run yet, so return to it, not past it.
        if (!stack_full) begin
          push            = 1'b1;
          push_data       = address_reg;
          address_next    = IRQ_VECTOR;
          irq_ack_next    = 1'b1;
          in_service_next = 1'b1;
        end else begin
          error_next = 1'b1;
        end
      end
`endif
      PC_OP_JUMP: address_next = jump_address;
      PC_OP_CALL: begin
        if (!stack_full) begin
          push         = 1'b1;
          address_next = jump_address;
        end else begin
          error_next = 1'b1;
        end
      end
      PC_OP_RET: begin
        if (!stack_empty) begin
          pop          = 1'b1;
          address_next = top_data;
`ifdef PC_IRQ_EN
          in_service_next = 1'b0;
`endif
        end else begin
          error_next = 1'b1;
        end
      end
      PC_OP_BRANCH: address_next = address_reg + offset_ext;
      PC_OP_COUNT:  address_next = address_reg + ADDR_W'(1);
      default:      address_next = address_reg;
    endcase
  end

  // Address register and sticky error flag; only reset clears the error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_reg <= RESET_VECTOR;
      error_reg   <= 1'b0;
    end else begin
      address_reg <= address_next;
      error_reg   <= error_next;
    end
  end

`ifdef PC_IRQ_EN
  // Interrupt acknowledge pulse and in-service mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_service_reg <= 1'b0;
      irq_ack_reg    <= 1'b0;
    end else begin
      in_service_reg <= in_service_next;
      irq_ack_reg    <= irq_ack_next;
    end
  end
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer (default parameters).
// The interrupt section is compiled only when PC_IRQ_EN is defined.
module tb_program_sequencer;

  logic        clk;
  logic        reset;
  logic        count_enable;
  logic        jump_enable;
  logic [15:0] jump_address;
  logic        branch_enable;
  logic [7:0]  branch_offset;
  logic        call_enable;
  logic        ret_enable;
  logic [15:0] address;
  logic [3:0]  stack_depth;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_error;
`ifdef PC_IRQ_EN
  logic        irq;
  logic        irq_ack;
`endif

  int checks   = 0;
  int failures = 0;

  program_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .count_enable  (count_enable),
    .jump_enable   (jump_enable),
    .jump_address  (jump_address),
    .branch_enable (branch_enable),
    .branch_offset (branch_offset),
    .call_enable   (call_enable),
    .ret_enable    (ret_enable),
    .address       (address),
    .stack_depth   (stack_depth),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .stack_error   (stack_error)
`ifdef PC_IRQ_EN
    ,
    .irq           (irq),
    .irq_ack       (irq_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end else begin
      $display("ok   %s value=%0h", tag, observed);
    end
  endtask

  task automatic idle();
    count_enable  = 1'b0;
    jump_enable   = 1'b0;
    branch_enable = 1'b0;
    call_enable   = 1'b0;
    ret_enable    = 1'b0;
    jump_address  = 16'h0000;
    branch_offset = 8'h00;
`ifdef PC_IRQ_EN
    irq = 1'b0;
`endif
  endtask

  // Apply the current strobes for one rising edge, then settle at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    check("rst_address", 32'(address), 32'h0000);
    check("rst_depth",   32'(stack_depth), 0);
    check("rst_empty",   32'(stack_empty), 1);
    check("rst_full",    32'(stack_full), 0);
    check("rst_error",   32'(stack_error), 0);
    @(negedge clk);
    reset = 1'b0;

    // Counting and hold
    for (int i = 1; i <= 3; i++) begin
      count_enable = 1'b1; step();
      check($sformatf("count_%0d", i), 32'(address), 32'(i));
    end
    step();
    check("hold", 32'(address), 32'h0003);

    // Call and return
    jump_enable = 1'b1; jump_address = 16'h0005; step();
    check("jump_5", 32'(address), 32'h0005);
    call_enable = 1'b1; jump_address = 16'haa98; step();
    check("call_addr",  32'(address), 32'haa98);
    check("call_depth", 32'(stack_depth), 1);
    ret_enable = 1'b1; step();
    check("ret_addr",  32'(address), 32'h0006);
    check("ret_depth", 32'(stack_depth), 0);
    check("ret_empty", 32'(stack_empty), 1);

    // Fill the stack, then overflow
    for (int k = 0; k < 8; k++) begin
      call_enable = 1'b1; jump_address = 16'(16'h0200 + 2 * k); step();
    end
    check("fill_addr",  32'(address), 32'h020E);
    check("fill_depth", 32'(stack_depth), 8);
    check("fill_full",  32'(stack_full), 1);
    check("fill_error", 32'(stack_error), 0);
    call_enable = 1'b1; jump_address = 16'h0300; step();
    check("ovf_addr",  32'(address), 32'h020E);
    check("ovf_error", 32'(stack_error), 1);
    check("ovf_depth", 32'(stack_depth), 8);
    ret_enable = 1'b1; step();
    check("ovf_ret_addr",  32'(address), 32'h020D);
    check("ovf_ret_depth", 32'(stack_depth), 7);
    check("err_sticky",    32'(stack_error), 1);
    reset = 1'b1; #1;
    check("rst2_error",   32'(stack_error), 0);
    check("rst2_address", 32'(address), 32'h0000);
    check("rst2_depth",   32'(stack_depth), 0);
    @(negedge clk);
    reset = 1'b0;

    // Underflow
    count_enable = 1'b1; step();
    count_enable = 1'b1; step();
    ret_enable = 1'b1; step();
    check("unf_addr",  32'(address), 32'h0002);
    check("unf_error", 32'(stack_error), 1);
    check("unf_depth", 32'(stack_depth), 0);

    // Relative branches and wrap-around
    do_reset();
    jump_enable = 1'b1; jump_address = 16'h0010; step();
    branch_enable = 1'b1; branch_offset = 8'hFC; step();
    check("br_neg4", 32'(address), 32'h000C);
    branch_enable = 1'b1; branch_offset = 8'h00; step();
    check("br_zero", 32'(address), 32'h000C);
    jump_enable = 1'b1; jump_address = 16'hFFFE; step();
    branch_enable = 1'b1; branch_offset = 8'h03; step();
    check("br_wrap", 32'(address), 32'h0001);
    branch_enable = 1'b1; branch_offset = 8'h80; step();
    check("br_min", 32'(address), 32'hFF81);
    jump_enable = 1'b1; jump_address = 16'hFFFF; step();
    count_enable = 1'b1; step();
    check("count_wrap", 32'(address), 32'h0000);

    // Simultaneous strobes
    jump_enable = 1'b1; call_enable = 1'b1; count_enable = 1'b1;
    jump_address = 16'h1234; step();
    check("jcc_addr",  32'(address), 32'h1234);
    check("jcc_depth", 32'(stack_depth), 0);
    call_enable = 1'b1; ret_enable = 1'b1; jump_address = 16'h0050; step();
    check("cr_addr",  32'(address), 32'h0050);
    check("cr_depth", 32'(stack_depth), 1);
    ret_enable = 1'b1; branch_enable = 1'b1; branch_offset = 8'h05; step();
    check("rb_addr",  32'(address), 32'h1235);
    check("rb_depth", 32'(stack_depth), 0);
    branch_enable = 1'b1; count_enable = 1'b1; branch_offset = 8'h02; step();
    check("bc_addr", 32'(address), 32'h1237);

    // Asynchronous reset in the middle of a call sequence
    do_reset();
    for (int k = 0; k < 3; k++) begin
      call_enable = 1'b1; jump_address = 16'(16'h0400 + 16 * k); step();
    end
    check("mid_depth", 32'(stack_depth), 3);
    call_enable = 1'b1; jump_address = 16'h0430;
    reset = 1'b1; #1;
    check("mid_rst_depth", 32'(stack_depth), 0);
    check("mid_rst_addr",  32'(address), 32'h0000);
    check("mid_rst_empty", 32'(stack_empty), 1);
    @(posedge clk);
    @(negedge clk);
    idle();
    reset = 1'b0;

`ifdef PC_IRQ_EN
    // Interrupt entry, masking while in service, and return
    jump_enable = 1'b1; jump_address = 16'h0042; step();
    irq = 1'b1; step();
    check("irq_addr",  32'(address), 32'h0010);
    check("irq_ack",   32'(irq_ack), 1);
    check("irq_depth", 32'(stack_depth), 1);
    irq = 1'b1; count_enable = 1'b1; step();
    check("irq_mask_addr", 32'(address), 32'h0011);
    check("irq_ack_pulse", 32'(irq_ack), 0);
    ret_enable = 1'b1; step();
    check("irq_ret_addr",  32'(address), 32'h0042);
    check("irq_ret_depth", 32'(stack_depth), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
